// File: rtl/hilo_commit_unit_if.sv
// HI/LO commit unit bus: EX-stage write request, M/W pipeline control,
// and the forwarded/architectural HI/LO results.
interface hilo_commit_unit_if #(
  parameter int HALF_W = 32
);
  logic                  wen_e;
  logic [1:0]            sel_e;
  logic [2*HALF_W-1:0]   wdata_e;
  logic                  stall_m;
  logic                  flush_m;
  logic                  exc_m;
  logic                  stall_w;
  logic                  flush_w;
  logic [2*HALF_W-1:0]   hilo_o;
  logic [HALF_W-1:0]     hi_arch;
  logic [HALF_W-1:0]     lo_arch;
  logic                  commit_w;
  logic [1:0]            commit_sel;

  modport master (
    output wen_e, sel_e, wdata_e, stall_m, flush_m, exc_m, stall_w, flush_w,
    input  hilo_o, hi_arch, lo_arch, commit_w, commit_sel
  );

  modport slave (
    input  wen_e, sel_e, wdata_e, stall_m, flush_m, exc_m, stall_w, flush_w,
    output hilo_o, hi_arch, lo_arch, commit_w, commit_sel
  );
endinterface

// File: rtl/hilo_commit_unit.sv
// HI/LO commit unit: carries EX-stage HI/LO writes through the M and W slots,
// commits them to the architectural pair when they leave W un-flushed, and
// forwards the youngest in-flight value back to the EX-stage ALU.
module hilo_commit_unit #(
  parameter int HALF_W = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  hilo_commit_unit_if.slave bus
);
  localparam int DW = 2 * HALF_W;

  typedef struct packed {
    logic          v;
    logic [1:0]    sel;
    logic [DW-1:0] d;
  } slot_t;

  slot_t         m_q, m_d;
  slot_t         w_q, w_d;
  logic [DW-1:0] arch_q, arch_d;
  logic          commit;

  // Next state of the M/W slots and the architectural pair.
  always_comb begin
    m_d    = m_q;
    w_d    = w_q;
    arch_d = arch_q;
    commit = w_q.v & ~bus.stall_w & ~bus.flush_w;

    if (bus.flush_m) begin
      m_d.v = 1'b0;
    end else if (!bus.stall_m) begin
      m_d.v   = bus.wen_e;
      m_d.sel = bus.sel_e;
      m_d.d   = bus.wdata_e;
    end

    // A stalled M slot feeds a bubble into W; an excepting M entry dies here.
    if (bus.flush_w) begin
      w_d.v = 1'b0;
    end else if (!bus.stall_w) begin
      if (bus.stall_m) begin
        w_d.v = 1'b0;
      end else begin
        w_d.v   = m_q.v & ~bus.exc_m;
        w_d.sel = m_q.sel;
        w_d.d   = m_q.d;
      end
    end

    if (commit) arch_d = w_q.d;
  end

  // State registers; reset discards in-flight entries and clears HI/LO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_q    <= '0;
      w_q    <= '0;
      arch_q <= '0;
    end else begin
      m_q    <= m_d;
      w_q    <= w_d;
      arch_q <= arch_d;
    end
  end

  // Forwarding mux: youngest un-excepted in-flight write wins.
  generate
    if (FWD_EN) begin : g_fwd
      always_comb begin
        bus.hilo_o = arch_q;
        if (m_q.v && !bus.exc_m) bus.hilo_o = m_q.d;
        else if (w_q.v)          bus.hilo_o = w_q.d;
      end
    end else begin : g_nofwd
      always_comb begin
        bus.hilo_o = arch_q;
      end
    end
  endgenerate

  // Architectural view and commit trace.
  always_comb begin
    bus.hi_arch    = arch_q[DW-1:HALF_W];
    bus.lo_arch    = arch_q[HALF_W-1:0];
    bus.commit_w   = commit;
    bus.commit_sel = commit ? w_q.sel : 2'b00;
  end
endmodule

// File: tb/tb_hilo_commit_unit.sv
// Bench for hilo_commit_unit: directed scenarios plus random traffic, all
// checked against a transaction-level model of the M/W slots and HI/LO.
module tb_hilo_commit_unit;
  localparam int HW = 32;
  localparam int DW = 2 * HW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_commit_unit_if #(.HALF_W(HW)) bus_f ();
  hilo_commit_unit_if #(.HALF_W(HW)) bus_n ();

  hilo_commit_unit #(.HALF_W(HW), .FWD_EN(1'b1)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));
  hilo_commit_unit #(.HALF_W(HW), .FWD_EN(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  int vectors = 0;
  int miscompares = 0;

  // Reference: each slot is an optional in-flight write record.
  typedef struct { bit v; bit [1:0] sel; bit [DW-1:0] d; } entry_t;
  entry_t     mdl_m, mdl_w;
  bit [DW-1:0] mdl_arch;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // The hazard unit never stalls W alone.
  always @(posedge clk)
    if (rst === 1'b1)
      assert (!(bus_f.stall_w && !bus_f.stall_m)) else $error("illegal stall_w without stall_m");

  // Apply one cycle: drive inputs, check outputs against the model, clock.
  task automatic cyc(input bit r, input bit wen, input bit [1:0] sel, input bit [DW-1:0] wd,
                     input bit sm, input bit fm, input bit ex, input bit sw, input bit fw);
    bit [DW-1:0] e_hilo;
    bit          e_commit;
    entry_t      nm, nw;
    rst = r;
    bus_f.wen_e = wen; bus_f.sel_e = sel; bus_f.wdata_e = wd;
    bus_f.stall_m = sm; bus_f.flush_m = fm; bus_f.exc_m = ex;
    bus_f.stall_w = sw; bus_f.flush_w = fw;
    bus_n.wen_e = wen; bus_n.sel_e = sel; bus_n.wdata_e = wd;
    bus_n.stall_m = sm; bus_n.flush_m = fm; bus_n.exc_m = ex;
    bus_n.stall_w = sw; bus_n.flush_w = fw;
    #1;
    if (mdl_m.v && !ex) e_hilo = mdl_m.d;
    else if (mdl_w.v)   e_hilo = mdl_w.d;
    else                e_hilo = mdl_arch;
    e_commit = mdl_w.v && !sw && !fw;
    chk("hilo_fwd",   bus_f.hilo_o, e_hilo);
    chk("hilo_nofwd", bus_n.hilo_o, mdl_arch);
    chk("hi_arch",    {32'b0, bus_f.hi_arch}, {32'b0, mdl_arch[DW-1:HW]});
    chk("lo_arch",    {32'b0, bus_f.lo_arch}, {32'b0, mdl_arch[HW-1:0]});
    chk("commit_w",   {63'b0, bus_f.commit_w}, {63'b0, e_commit});
    chk("commit_sel", {62'b0, bus_f.commit_sel}, {62'b0, (e_commit ? mdl_w.sel : 2'b00)});
    @(posedge clk);
    if (!r) begin
      mdl_m = '{0, 0, 0}; mdl_w = '{0, 0, 0}; mdl_arch = '0;
    end else begin
      if (e_commit) mdl_arch = mdl_w.d;
      nw = mdl_w;
      if (fw)      nw.v = 0;
      else if (sw) nw = mdl_w;
      else if (sm) nw.v = 0;
      else         nw = '{mdl_m.v && !ex, mdl_m.sel, mdl_m.d};
      nm = mdl_m;
      if (fm)       nm.v = 0;
      else if (!sm) nm = '{wen, sel, wd};
      mdl_m = nm; mdl_w = nw;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    mdl_m = '{0, 0, 0}; mdl_w = '{0, 0, 0}; mdl_arch = '0;
    rst = 1'b0;
    @(negedge clk);
    cyc(0, 0, 0, '0, 0, 0, 0, 0, 0);
    chk("reset_hilo", bus_f.hilo_o, '0);
    chk("reset_commit", {63'b0, bus_f.commit_w}, 64'd0);

    // MTHI-style write, visible architecturally three cycles later.
    cyc(1, 1, 2'b11, 64'h12345678_00000000, 0, 0, 0, 0, 0);
    chk("mthi_fwd_c1", bus_f.hilo_o, 64'h12345678_00000000);
    idle(2);
    chk("mthi_hi", {32'b0, bus_f.hi_arch}, 64'h12345678);
    chk("mthi_lo", {32'b0, bus_f.lo_arch}, 64'h0);

    // Back-to-back writes: youngest forwarded, arch ends at B.
    cyc(1, 1, 2'b00, 64'h1_00000002, 0, 0, 0, 0, 0);
    cyc(1, 1, 2'b00, 64'h3_00000004, 0, 0, 0, 0, 0);
    idle(3);
    chk("b2b_arch", {bus_f.hi_arch, bus_f.lo_arch}, 64'h3_00000004);

    // Exception in M kills the write.
    cyc(1, 1, 2'b10, 64'hDEAD_BEEF, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0, 1, 0, 0);
    idle(3);
    chk("exc_arch", {bus_f.hi_arch, bus_f.lo_arch}, 64'h3_00000004);

    // Write then three cycles of full stall with the entry parked in W.
    cyc(1, 1, 2'b01, 64'h5_00000006, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, '0, 1, 0, 0, 1, 0);
    idle(2);
    chk("stall_arch", {bus_f.hi_arch, bus_f.lo_arch}, 64'h5_00000006);

    // Flush of W on the would-be commit cycle.
    cyc(1, 1, 2'b00, 64'h7_00000008, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, 0, 1);
    idle(2);
    chk("flushw_arch", {bus_f.hi_arch, bus_f.lo_arch}, 64'h5_00000006);

    // Reset with both slots occupied.
    cyc(1, 1, 2'b00, 64'h9_0000000A, 0, 0, 0, 0, 0);
    cyc(1, 1, 2'b00, 64'hB_0000000C, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 0, 0, 0);
    chk("rst_mid_hilo", bus_f.hilo_o, '0);
    chk("rst_mid_arch", {bus_f.hi_arch, bus_f.lo_arch}, '0);

    // Non-forwarding instance tracks arch only.
    cyc(1, 1, 2'b00, 64'hAA_000000BB, 0, 0, 0, 0, 0);
    idle(3);
    chk("nofwd_final", bus_n.hilo_o, 64'hAA_000000BB);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit sm, sw;
      sm = ($urandom_range(0, 4) == 0);
      sw = sm && ($urandom_range(0, 1) == 1);
      cyc(($urandom_range(0, 49) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
          {$urandom, $urandom}, sm, ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 9) == 0), sw, ($urandom_range(0, 11) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
